// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a one-byte holding register,
// valid/ready byte input and an idle-high guard period after every reset.

package definitions_pkg;
   localparam int CLOCK_RATE = 18_432_000;
   localparam int BAUD_RATE  = 115_200;
endpackage

module uart_transmitter #(
   parameter int CLOCK_RATE = definitions_pkg::CLOCK_RATE,
   parameter int BAUD_RATE  = definitions_pkg::BAUD_RATE
) (
   input  logic       clk,
   input  logic       enabled,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int BIT_CYCLES   = CLOCK_RATE / BAUD_RATE;
   localparam int GUARD_CYCLES = 10 * BIT_CYCLES;
   localparam int CNT_W        = $clog2(BIT_CYCLES);
   localparam int GRD_W        = $clog2(GUARD_CYCLES);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
   localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'(GUARD_CYCLES - 1);

   if (CLOCK_RATE % BAUD_RATE != 0) begin : g_bad_ratio
      $fatal(1, "CLOCK_RATE must be an integer multiple of BAUD_RATE");
   end
   if (BIT_CYCLES < 8) begin : g_bad_bit_cycles
      $fatal(1, "BIT_CYCLES must be at least 8");
   end

   typedef enum logic [2:0] {GUARD, IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [GRD_W-1:0] guard_cnt_q, guard_cnt_d;
   logic             tx_q, tx_d;
   logic             accept;
   logic             bit_last;

   // Handshake and status derive from registered state only.
   assign ready    = enabled && (state_q != GUARD) && !hold_full_q;
   assign busy     = (state_q == START) || (state_q == DATA) || (state_q == STOP) || hold_full_q;
   assign tx       = tx_q;
   assign accept   = valid && ready;
   assign bit_last = (bit_cnt_q == BIT_LAST);

   // Next-state, counters, holding register and next line level.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      guard_cnt_d = guard_cnt_q;
      tx_d        = 1'b1;

      unique case (state_q)
         GUARD: begin
            if (guard_cnt_q == GUARD_LAST) begin
               guard_cnt_d = '0;
               state_d     = IDLE;
            end else begin
               guard_cnt_d = guard_cnt_q + GRD_W'(1);
            end
         end
         IDLE: begin
            if (accept) begin
               shift_d   = data;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START, DATA, STOP: begin
            // A byte offered mid-frame parks in the holding register, except on
            // the final stop cycle where it is loaded straight into the shifter.
            if (accept && !(state_q == STOP && bit_last)) begin
               hold_d      = data;
               hold_full_d = 1'b1;
            end
            bit_cnt_d = bit_last ? '0 : bit_cnt_q + CNT_W'(1);
            if (bit_last) begin
               unique case (state_q)
                  START: begin
                     bit_idx_d = 3'd0;
                     state_d   = DATA;
                  end
                  DATA: begin
                     if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                     end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                     end
                  end
                  default: begin
                     if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = START;
                     end else if (accept) begin
                        shift_d = data;
                        state_d = START;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               endcase
            end
         end
         default: state_d = GUARD;
      endcase

      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   // State register; a low enabled truncates any frame and drops the held byte.
   always_ff @(posedge clk) begin
      if (!enabled) begin
         state_q     <= GUARD;
         bit_cnt_q   <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         guard_cnt_q <= '0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         guard_cnt_q <= guard_cnt_d;
         tx_q        <= tx_d;
      end
   end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit end of the UART link. Takes bytes over a valid/ready handshake and drives an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on `tx`. Each bit lasts exactly `CLOCK_RATE/BAUD_RATE` system clocks. A one-byte holding register lets frames go back-to-back with no idle gap. After every reset the block drives a guaranteed idle-high guard period, so the far-end receiver synchronizer sees a stable high line before the first start bit.

## Interface
- `CLOCK_RATE`, default `definitions_pkg::CLOCK_RATE`: system clock frequency in Hz.
- `BAUD_RATE`, default `definitions_pkg::BAUD_RATE`: line bit rate in Hz.
- `clk` input, 1 bit: system clock. Only clock; all logic on posedge.
- `enabled` input, 1 bit: reset, synchronous and active-low. Low = held in reset.
- `data` input, 8 bits: byte to send. Sampled when `valid && ready`.
- `valid` input, 1 bit: `data` is offered.
- `ready` output, 1 bit: block accepts `data` this cycle.
- `tx` output, 1 bit: serial line. Registered; idle level high.
- `busy` output, 1 bit: a frame is being shifted out or a byte is pending.

## Operation
- `BIT_CYCLES = CLOCK_RATE / BAUD_RATE`. Bit counter width is `$clog2(BIT_CYCLES)`.
- Elaboration-time checks, each `$fatal`:
  - `CLOCK_RATE % BAUD_RATE != 0`.
  - `BIT_CYCLES < 8`.
- States: `GUARD`, `IDLE`, `START`, `DATA`, `STOP`.
- Reset values while `enabled` is low:
  - `tx = 1`, `ready = 0`, `busy = 0`.
  - State becomes `GUARD`; holding register is emptied; counters are cleared.
- `GUARD`:
  - `tx = 1`, `ready = 0`, `busy = 0`.
  - Lasts exactly `10*BIT_CYCLES` cycles after `enabled` rises, then goes to `IDLE`.
- `ready = enabled && state != GUARD && !hold_full`. Combinational from registered state only; never depends on `valid`.
- Accept in `IDLE`: the byte loads directly into the shifter and the state goes to `START`. The holding register stays empty.
- Accept in `START`/`DATA`/`STOP`: the byte goes into the holding register and `hold_full` is set.
- `START`: `tx = 0` for `BIT_CYCLES` cycles.
- `DATA`: shifts out bits 0..7, `BIT_CYCLES` cycles each. A 3-bit index counts 0..7.
- `STOP`: `tx = 1` for `BIT_CYCLES` cycles. On the final stop cycle edge, in priority order:
  - If `hold_full`: load from the holding register, clear `hold_full`, go to `START`.
  - Else if `valid && ready`: load `data` directly, go to `START`.
  - Else go to `IDLE`.
- `busy = (state` is `START`/`DATA`/`STOP`) `|| hold_full`.
- `data` is ignored whenever `ready` is low. A byte presented while `ready` is low is not lost; the source must hold it until accepted.
- Reset mid-frame: on the edge where `enabled` is sampled low, `tx` returns to 1 and the frame is truncated. The holding byte is discarded. The guard restarts when `enabled` rises.

## Timing
- Accept in `IDLE` at edge T: `tx = 0` from T+1. Latency is 1 cycle.
- Frame length is exactly `10*BIT_CYCLES` cycles.
- Back-to-back frames have a period of exactly `10*BIT_CYCLES`; the next start bit directly follows the last stop cycle.
- `ready`:
  - Drops the cycle after a mid-frame accept.
  - Rises the cycle after the holding byte is moved to the shifter.
- Accept and frame end in the same cycle: the direct-load path applies, with no gap and no lost byte.
- The bit counter wraps from `BIT_CYCLES-1` to 0 at each bit boundary. It never free-runs in `IDLE`/`GUARD`, so bit edges are aligned to the start bit.

## Test plan
- Guard: `BIT_CYCLES=8`, raise `enabled`, hold `valid=1` -> `tx=1` and `ready=0` for 80 cycles; `ready=1` on cycle 81; start bit on the next cycle.
- Single byte `0xA5` from `IDLE` -> `tx` = 0,1,0,1,0,0,1,0,1,1, each level 8 cycles. `busy` is high for 80 cycles, then low; `tx` stays 1.
- Back-to-back: send `0x00`, then `0xFF` during its first data bit -> `ready` low until the `0xFF` load. Output is 160 cycles total: frame 0x00, then frame 0xFF, with no idle cycle between.
- Stall: offer a third byte `0x3C` while the holding register is full -> it is not accepted until the second frame starts. `0x3C`'s frame follows gaplessly; no byte is duplicated or dropped.
- Accept on the final stop cycle with the holding register empty -> the next start bit begins on the following cycle.
- Reset mid-frame: drop `enabled` during data bit 3 with `0x55` pending in the holding register -> `tx=1`, `ready=0`, `busy=0` next cycle. After `enabled` rises: 80-cycle guard, and `0x55` is never transmitted.
